// File: rtl/obstacle_field_controller_pkg.sv
// Shared constants, FSM state encoding and small helpers for the obstacle field.
package obstacle_field_controller_pkg;

    localparam int COORD_W_DEF   = 10;
    localparam int SCREEN_W_DEF  = 640;
    localparam int OBS_WIDTH_DEF = 30;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    // Saturating increment used by the level speed ramp.
    function automatic logic [3:0] speed_step(input logic [3:0] cur, input logic [3:0] max);
        return (cur >= max) ? max : cur + 4'd1;
    endfunction

endpackage

// File: rtl/obstacle_field_controller_slot.sv
// One obstacle channel: holds position/valid, moves left on each tick, retires at the
// left edge or on a hit, and accepts a spawn load while free.
module obstacle_field_controller_slot #(
    parameter int COORD_W  = 10,
    parameter int SCREEN_W = 640
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [3:0]         speed,
    input  logic               load,
    input  logic [COORD_W-1:0] load_y,
    input  logic               hit,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               active,
    output logic               hit_evt
);

    logic [COORD_W-1:0] step;

    assign step    = COORD_W'(speed);
    // A hit only counts against a live obstacle on a processing tick.
    assign hit_evt = tick && active && hit;

    // Slot state: hit beats retirement beats movement; load only lands on a free slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x      <= '0;
            y      <= '0;
            active <= 1'b0;
        end else if (tick) begin
            if (active) begin
                if (hit) begin
                    active <= 1'b0;
                end else if (x < step) begin
                    active <= 1'b0;
                end else begin
                    x <= x - step;
                end
            end else if (load) begin
                active <= 1'b1;
                x      <= COORD_W'(SCREEN_W);
                y      <= load_y;
            end
        end
    end

endmodule

// File: rtl/obstacle_field_controller.sv
// Multi-slot obstacle controller: run/pause FSM, spawn scheduling onto the lowest free
// slot, level-based speed ramp and packing of per-slot state onto flat output buses.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  ST_IDLE   | waiting for start, everything at reset values
//  ST_RUN    | game ticks move, retire and spawn obstacles
//  ST_PAUSED | all state frozen until pause drops
module obstacle_field_controller
    import obstacle_field_controller_pkg::*;
#(
    parameter int NUM_OBS     = 4,
    parameter int COORD_W     = COORD_W_DEF,
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int OBS_WIDTH   = OBS_WIDTH_DEF,
    parameter int Y_BASE      = 50,
    parameter int Y_RAND_W    = 8,
    parameter int SPAWN_GAP   = 40,
    parameter int SPEED_INIT  = 2,
    parameter int SPEED_MAX   = 8,
    parameter int LEVEL_TICKS = 600
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       game_en,
    input  logic                       start,
    input  logic                       pause,
    input  logic [15:0]                rand_in,
    input  logic [NUM_OBS-1:0]         hit_in,
    output logic [NUM_OBS*COORD_W-1:0] obs_x,
    output logic [NUM_OBS*COORD_W-1:0] obs_y,
    output logic [NUM_OBS-1:0]         obs_active,
    output logic [COORD_W-1:0]         obs_size,
    output logic [3:0]                 speed,
    output logic                       spawn_pulse,
    output logic                       hit_pulse,
    output logic                       running
);

    localparam int SC_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
    localparam int LV_W = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;

    if (NUM_OBS < 1 || NUM_OBS > 8) begin : g_chk_num
        $error("NUM_OBS must be in 1..8");
    end
    if (Y_RAND_W < 1 || Y_RAND_W > 16) begin : g_chk_rand
        $error("Y_RAND_W must be in 1..16");
    end
    if (Y_BASE + (1 << Y_RAND_W) - 1 > (1 << COORD_W) - 1) begin : g_chk_y
        $error("Y_BASE + 2^Y_RAND_W - 1 does not fit COORD_W");
    end
    if (SCREEN_W > (1 << COORD_W) - 1) begin : g_chk_x
        $error("SCREEN_W does not fit COORD_W");
    end

    state_t             state, state_nxt;
    logic               tick;
    logic               spawn_due;
    logic               found;
    logic [NUM_OBS-1:0] slot_active;
    logic [NUM_OBS-1:0] load_vec;
    logic [NUM_OBS-1:0] hit_evt;
    logic [COORD_W-1:0] slot_x [NUM_OBS];
    logic [COORD_W-1:0] slot_y [NUM_OBS];
    logic [COORD_W-1:0] load_y;
    logic [SC_W-1:0]    spawn_cnt;
    logic [LV_W-1:0]    lvl_cnt;
    logic               unused_rand;

    assign tick        = game_en && (state == ST_RUN);
    assign spawn_due   = tick && (spawn_cnt == '0);
    assign load_y      = COORD_W'(Y_BASE) + COORD_W'(rand_in[Y_RAND_W-1:0]);
    assign unused_rand = ^rand_in;
    assign running     = (state == ST_RUN);
    assign obs_size    = COORD_W'(OBS_WIDTH);
    assign obs_active  = slot_active;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // FSM next-state: IDLE is only left on start and only re-entered through reset.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start)  state_nxt = ST_RUN;
            ST_RUN:    if (pause)  state_nxt = ST_PAUSED;
            ST_PAUSED: if (!pause) state_nxt = ST_RUN;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Lowest-index free slot, judged on occupancy at tick start.
    always_comb begin
        load_vec = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (!found && !slot_active[i]) begin
                load_vec[i] = 1'b1;
                found       = 1'b1;
            end
        end
        if (!spawn_due) load_vec = '0;
    end

    // Spawn gap down-counter; parks at zero while every slot is busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spawn_cnt <= '0;
        end else if (tick) begin
            if (spawn_cnt == '0) begin
                if (|load_vec) spawn_cnt <= SC_W'(SPAWN_GAP - 1);
            end else begin
                spawn_cnt <= spawn_cnt - SC_W'(1);
            end
        end
    end

    // Level counter and speed ramp; the new speed applies from the following tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_cnt <= '0;
            speed   <= 4'(SPEED_INIT);
        end else if (tick) begin
            if (lvl_cnt == LV_W'(LEVEL_TICKS - 1)) begin
                lvl_cnt <= '0;
                speed   <= speed_step(speed, 4'(SPEED_MAX));
            end else begin
                lvl_cnt <= lvl_cnt + LV_W'(1);
            end
        end
    end

    // Event strobes, one cycle after the tick that caused them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spawn_pulse <= 1'b0;
            hit_pulse   <= 1'b0;
        end else begin
            spawn_pulse <= |load_vec;
            hit_pulse   <= |hit_evt;
        end
    end

    for (genvar i = 0; i < NUM_OBS; i++) begin : g_slot
        obstacle_field_controller_slot #(
            .COORD_W  (COORD_W),
            .SCREEN_W (SCREEN_W)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .speed   (speed),
            .load    (load_vec[i]),
            .load_y  (load_y),
            .hit     (hit_in[i]),
            .x       (slot_x[i]),
            .y       (slot_y[i]),
            .active  (slot_active[i]),
            .hit_evt (hit_evt[i])
        );
        assign obs_x[i*COORD_W +: COORD_W] = slot_x[i];
        assign obs_y[i*COORD_W +: COORD_W] = slot_y[i];
    end

endmodule

// File: tb/tb_obstacle_field_controller.sv
// Bench for obstacle_field_controller: three instances (default, SPAWN_GAP=1,
// LEVEL_TICKS=10) share stimulus; a behavioural model of the selected instance pushes
// expected snapshots that a monitor pops one cycle later.
module tb_obstacle_field_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        game_en = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [15:0] rand_in = 16'h0;
    logic [3:0]  hit_in = 4'h0;

    logic [39:0] ox   [3];
    logic [39:0] oy   [3];
    logic [3:0]  oact [3];
    logic [9:0]  osz  [3];
    logic [3:0]  ospd [3];
    logic        osp  [3];
    logic        ohp  [3];
    logic        orun [3];

    int n_checks = 0;
    int n_fail   = 0;
    int sel      = 0;

    always #5 clk = ~clk;

    obstacle_field_controller u_dut_a (
        .clk(clk), .rst(rst), .game_en(game_en), .start(start), .pause(pause),
        .rand_in(rand_in), .hit_in(hit_in), .obs_x(ox[0]), .obs_y(oy[0]),
        .obs_active(oact[0]), .obs_size(osz[0]), .speed(ospd[0]),
        .spawn_pulse(osp[0]), .hit_pulse(ohp[0]), .running(orun[0]));

    obstacle_field_controller #(.SPAWN_GAP(1)) u_dut_b (
        .clk(clk), .rst(rst), .game_en(game_en), .start(start), .pause(pause),
        .rand_in(rand_in), .hit_in(hit_in), .obs_x(ox[1]), .obs_y(oy[1]),
        .obs_active(oact[1]), .obs_size(osz[1]), .speed(ospd[1]),
        .spawn_pulse(osp[1]), .hit_pulse(ohp[1]), .running(orun[1]));

    obstacle_field_controller #(.LEVEL_TICKS(10)) u_dut_c (
        .clk(clk), .rst(rst), .game_en(game_en), .start(start), .pause(pause),
        .rand_in(rand_in), .hit_in(hit_in), .obs_x(ox[2]), .obs_y(oy[2]),
        .obs_active(oact[2]), .obs_size(osz[2]), .speed(ospd[2]),
        .spawn_pulse(osp[2]), .hit_pulse(ohp[2]), .running(orun[2]));

    typedef struct {
        logic [3:0]  act;
        logic [39:0] x;
        logic [39:0] y;
        logic [3:0]  spd;
        logic        sp;
        logic        hp;
        logic        run;
    } exp_t;

    exp_t exp_q[$];

    int cfg_gap [3] = '{40, 1, 40};
    int cfg_lt  [3] = '{600, 600, 10};

    logic [9:0] mx [4];
    logic [9:0] my [4];
    logic [3:0] mact;
    int         mspd, mcnt, mlvl, mst;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mx[i] = '0;
            my[i] = '0;
        end
        mact = '0;
        mspd = 2;
        mcnt = 0;
        mlvl = 0;
        mst  = 0;
        exp_q.delete();
    endtask

    // Advance the model by one clock with the given inputs and queue the expected outputs.
    task automatic model_cycle(input logic ge, input logic st, input logic ps,
                               input logic [15:0] r, input logic [3:0] h);
        exp_t       e;
        logic [3:0] free;
        logic       sp = 1'b0;
        logic       hp = 1'b0;
        logic       done = 1'b0;
        if (ge && mst == 1) begin
            free = ~mact;
            for (int i = 0; i < 4; i++) begin
                if (mact[i]) begin
                    if (h[i]) begin
                        mact[i] = 1'b0;
                        hp = 1'b1;
                    end else if (int'(mx[i]) < mspd) begin
                        mact[i] = 1'b0;
                    end else begin
                        mx[i] = mx[i] - 10'(mspd);
                    end
                end
            end
            if (mcnt == 0) begin
                for (int i = 0; i < 4; i++) begin
                    if (!done && free[i]) begin
                        done    = 1'b1;
                        mact[i] = 1'b1;
                        mx[i]   = 10'd640;
                        my[i]   = 10'(50 + int'(r[7:0]));
                        sp      = 1'b1;
                        mcnt    = cfg_gap[sel] - 1;
                    end
                end
            end else begin
                mcnt--;
            end
            if (mlvl == cfg_lt[sel] - 1) begin
                mlvl = 0;
                if (mspd < 8) mspd++;
            end else begin
                mlvl++;
            end
        end
        case (mst)
            0: if (st) mst = 1;
            1: if (ps) mst = 2;
            default: if (!ps) mst = 1;
        endcase
        e.act = mact;
        e.x   = {mx[3], mx[2], mx[1], mx[0]};
        e.y   = {my[3], my[2], my[1], my[0]};
        e.spd = 4'(mspd);
        e.sp  = sp;
        e.hp  = hp;
        e.run = (mst == 1);
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: one queued snapshot per clock, compared 1 ns after the edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks += 7;
            if (oact[sel] !== e.act) begin n_fail++; $display("FAIL sb_active: got %b expected %b at %0t", oact[sel], e.act, $time); end
            if (ox[sel] !== e.x)     begin n_fail++; $display("FAIL sb_x: got %h expected %h at %0t", ox[sel], e.x, $time); end
            if (oy[sel] !== e.y)     begin n_fail++; $display("FAIL sb_y: got %h expected %h at %0t", oy[sel], e.y, $time); end
            if (ospd[sel] !== e.spd) begin n_fail++; $display("FAIL sb_speed: got %0d expected %0d at %0t", ospd[sel], e.spd, $time); end
            if (osp[sel] !== e.sp)   begin n_fail++; $display("FAIL sb_spawn_pulse: got %b expected %b at %0t", osp[sel], e.sp, $time); end
            if (ohp[sel] !== e.hp)   begin n_fail++; $display("FAIL sb_hit_pulse: got %b expected %b at %0t", ohp[sel], e.hp, $time); end
            if (orun[sel] !== e.run) begin n_fail++; $display("FAIL sb_running: got %b expected %b at %0t", orun[sel], e.run, $time); end
        end
    end

    task automatic step(input logic ge, input logic st, input logic ps,
                        input logic [15:0] r, input logic [3:0] h);
        @(negedge clk);
        game_en = ge;
        start   = st;
        pause   = ps;
        rand_in = r;
        hit_in  = h;
        model_cycle(ge, st, ps, r, h);
        @(posedge clk);
        #2;
        game_en = 1'b0;
        hit_in  = 4'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        game_en = 1'b0;
        start   = 1'b0;
        pause   = 1'b0;
        hit_in  = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        sel = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        n_checks += 6;
        if (oact[0] !== 4'h0)  begin n_fail++; $display("FAIL reset_active: got %b expected 0000", oact[0]); end
        if (ox[0] !== 40'h0)   begin n_fail++; $display("FAIL reset_x: got %h expected 0", ox[0]); end
        if (oy[0] !== 40'h0)   begin n_fail++; $display("FAIL reset_y: got %h expected 0", oy[0]); end
        if (ospd[0] !== 4'd2)  begin n_fail++; $display("FAIL reset_speed: got %0d expected 2", ospd[0]); end
        if (orun[0] !== 1'b0 || osp[0] !== 1'b0 || ohp[0] !== 1'b0)
            begin n_fail++; $display("FAIL reset_flags: got run=%b sp=%b hp=%b expected 0", orun[0], osp[0], ohp[0]); end
        if (osz[0] !== 10'd30) begin n_fail++; $display("FAIL obs_size: got %0d expected 30", osz[0]); end
        do_reset();
    endtask

    task automatic test_first_spawn();
        sel = 0;
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0123, 4'h0);
        n_checks += 5;
        if (oact[0] !== 4'b0001)        begin n_fail++; $display("FAIL first_active: got %b expected 0001", oact[0]); end
        if (ox[0][9:0] !== 10'd640)     begin n_fail++; $display("FAIL first_x: got %0d expected 640", ox[0][9:0]); end
        if (oy[0][9:0] !== 10'd85)      begin n_fail++; $display("FAIL first_y: got %0d expected 85", oy[0][9:0]); end
        if (osp[0] !== 1'b1)            begin n_fail++; $display("FAIL first_spawn_pulse: got %b expected 1", osp[0]); end
        if (orun[0] !== 1'b1)           begin n_fail++; $display("FAIL first_running: got %b expected 1", orun[0]); end
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        n_checks++;
        if (osp[0] !== 1'b0)            begin n_fail++; $display("FAIL spawn_pulse_width: got %b expected 0", osp[0]); end
    endtask

    task automatic test_movement();
        sel = 0;
        for (int t = 2; t <= 322; t++) begin
            step(1'b1, 1'b1, 1'b0, 16'($urandom), 4'h0);
            if (t == 2) begin
                n_checks++;
                if (ox[0][9:0] !== 10'd638) begin n_fail++; $display("FAIL move_x_t2: got %0d expected 638", ox[0][9:0]); end
            end
            if (t == 321) begin
                n_checks++;
                if (ox[0][9:0] !== 10'd0 || oact[0][0] !== 1'b1)
                    begin n_fail++; $display("FAIL move_x_t321: got x=%0d act=%b expected x=0 act=1", ox[0][9:0], oact[0][0]); end
            end
            if (t == 322) begin
                n_checks++;
                if (oact[0][0] !== 1'b0 || ohp[0] !== 1'b0)
                    begin n_fail++; $display("FAIL retire_t322: got act=%b hp=%b expected act=0 hp=0", oact[0][0], ohp[0]); end
            end
        end
    endtask

    task automatic test_fill_and_hit();
        logic [3:0] em;
        sel = 1;
        do_reset();
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 16'($urandom), 4'h0);
            em = 4'((1 << k) - 1);
            n_checks++;
            if (oact[1] !== em || osp[1] !== 1'b1)
                begin n_fail++; $display("FAIL fill_tick%0d: got act=%b sp=%b expected act=%b sp=1", k, oact[1], osp[1], em); end
        end
        step(1'b1, 1'b1, 1'b0, 16'($urandom), 4'h0);
        n_checks++;
        if (oact[1] !== 4'hF || osp[1] !== 1'b0)
            begin n_fail++; $display("FAIL full_no_spawn: got act=%b sp=%b expected act=1111 sp=0", oact[1], osp[1]); end
        step(1'b1, 1'b1, 1'b0, 16'($urandom), 4'b0010);
        n_checks++;
        if (oact[1] !== 4'b1101 || ohp[1] !== 1'b1 || osp[1] !== 1'b0)
            begin n_fail++; $display("FAIL hit_slot1: got act=%b hp=%b sp=%b expected act=1101 hp=1 sp=0", oact[1], ohp[1], osp[1]); end
        step(1'b1, 1'b1, 1'b0, 16'($urandom), 4'h0);
        n_checks++;
        if (oact[1] !== 4'hF || osp[1] !== 1'b1 || ohp[1] !== 1'b0)
            begin n_fail++; $display("FAIL respawn_slot1: got act=%b sp=%b hp=%b expected act=1111 sp=1 hp=0", oact[1], osp[1], ohp[1]); end
    endtask

    task automatic test_speed_ramp();
        int es;
        sel = 2;
        do_reset();
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        for (int t = 1; t <= 75; t++) begin
            step(1'b1, 1'b1, 1'b0, 16'($urandom), 4'h0);
            es = (2 + t / 10 > 8) ? 8 : 2 + t / 10;
            if (t == 9 || t == 10 || t == 20 || t == 70 || t == 75) begin
                n_checks++;
                if (ospd[2] !== 4'(es)) begin n_fail++; $display("FAIL speed_t%0d: got %0d expected %0d", t, ospd[2], es); end
            end
        end
    endtask

    task automatic test_pause();
        sel = 0;
        do_reset();
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        for (int t = 1; t <= 5; t++) step(1'b1, 1'b1, 1'b0, 16'h0123, 4'h0);
        step(1'b0, 1'b1, 1'b1, 16'h0, 4'h0);
        for (int t = 0; t < 50; t++) step(1'b1, 1'b1, 1'b1, 16'($urandom), 4'hF);
        n_checks += 2;
        if (ox[0][9:0] !== 10'd632 || oact[0] !== 4'b0001)
            begin n_fail++; $display("FAIL pause_hold: got x=%0d act=%b expected x=632 act=0001", ox[0][9:0], oact[0]); end
        if (orun[0] !== 1'b0) begin n_fail++; $display("FAIL pause_running: got %b expected 0", orun[0]); end
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        n_checks++;
        if (ox[0][9:0] !== 10'd630 || orun[0] !== 1'b1)
            begin n_fail++; $display("FAIL pause_resume: got x=%0d run=%b expected x=630 run=1", ox[0][9:0], orun[0]); end
    endtask

    task automatic test_async_reset();
        sel = 0;
        step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (oact[0] !== 4'h0 || ox[0] !== 40'h0 || orun[0] !== 1'b0 || ospd[0] !== 4'd2)
            begin n_fail++; $display("FAIL async_reset: got act=%b x=%h run=%b spd=%0d expected all clear, spd=2", oact[0], ox[0], orun[0], ospd[0]); end
        model_reset();
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int t = 0; t < 3; t++) step(1'b1, 1'b0, 1'b0, 16'($urandom), 4'h0);
        n_checks++;
        if (orun[0] !== 1'b0 || oact[0] !== 4'h0)
            begin n_fail++; $display("FAIL idle_after_reset: got run=%b act=%b expected 0/0000", orun[0], oact[0]); end
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0005, 4'h0);
        n_checks++;
        if (oact[0] !== 4'b0001 || oy[0][9:0] !== 10'd55)
            begin n_fail++; $display("FAIL restart_spawn: got act=%b y=%0d expected 0001/55", oact[0], oy[0][9:0]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_first_spawn();
        test_movement();
        test_fill_and_hit();
        test_speed_ramp();
        test_pause();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
